// File: rtl/dual_port_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : dual_port_regfile
//  Purpose  : 32 x 32 architectural register file for the dual-issue pipeline.
//             Two write-back ports, four combinational read ports, r0 tied to
//             zero, same-register writes resolved in favour of slot 2, and a
//             free-running count of committed register writes.
//  Options  : define REGFILE_BYPASS_EN to forward same-cycle write data to the
//             read ports (slot 2 takes priority over slot 1).
//  Revision : 1.0  initial release
// ============================================================================
module dual_port_regfile #(
  parameter int WS_TO_RF_BUS_WD = 76
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [WS_TO_RF_BUS_WD-1:0] ws_to_rf_bus,
  input  logic [4:0]                 raddr1_1,
  input  logic [4:0]                 raddr1_2,
  input  logic [4:0]                 raddr2_1,
  input  logic [4:0]                 raddr2_2,
  output logic [31:0]                rdata1_1,
  output logic [31:0]                rdata1_2,
  output logic [31:0]                rdata2_1,
  output logic [31:0]                rdata2_2,
  output logic [31:0]                rf_write_cnt
);

  localparam logic [4:0] c_zero_addr = 5'd0;

  // Write-back bus fields
  logic        w_we1;
  logic        w_we2;
  logic [4:0]  w_waddr1;
  logic [4:0]  w_waddr2;
  logic [31:0] w_wdata1;
  logic [31:0] w_wdata2;

  // Qualified write enables and commit bookkeeping
  logic        w_eff1;
  logic        w_eff2;
  logic        w_same;
  logic [1:0]  w_inc;

  // Storage for r1..r31; r0 has no flops at all
  logic [31:0] r_regs [1:31];
  logic [31:0] r_write_cnt;

  assign w_we2    = ws_to_rf_bus[75];
  assign w_waddr2 = ws_to_rf_bus[74:70];
  assign w_wdata2 = ws_to_rf_bus[69:38];
  assign w_we1    = ws_to_rf_bus[37];
  assign w_waddr1 = ws_to_rf_bus[36:32];
  assign w_wdata1 = ws_to_rf_bus[31:0];

  // Gating with resetn keeps any bypassed data off the read ports during reset
  assign w_eff1 = resetn & w_we1 & (w_waddr1 != c_zero_addr);
  assign w_eff2 = resetn & w_we2 & (w_waddr2 != c_zero_addr);
  assign w_same = w_eff1 & w_eff2 & (w_waddr1 == w_waddr2);
  assign w_inc  = {1'b0, w_eff1} + {1'b0, w_eff2} - {1'b0, w_same};

  // Commit both write ports; slot 2 is assigned last so it wins on a collision
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 1; i < 32; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      if (w_eff1) r_regs[w_waddr1] <= w_wdata1;
      if (w_eff2) r_regs[w_waddr2] <= w_wdata2;
    end
  end

  // Count distinct registers written this edge; wraps naturally at 2^32
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_write_cnt <= '0;
    end else begin
      r_write_cnt <= r_write_cnt + {30'd0, w_inc};
    end
  end

  // One read port: r0 reads zero, otherwise array (optionally bypassed)
  function automatic logic [31:0] f_read(input logic [4:0] addr);
    logic [31:0] v;
    v = '0;
    if (addr != c_zero_addr) begin
`ifdef REGFILE_BYPASS_EN
      if (w_eff2 && (addr == w_waddr2)) begin
        v = w_wdata2;
      end else if (w_eff1 && (addr == w_waddr1)) begin
        v = w_wdata1;
      end else begin
        v = r_regs[addr];
      end
`else
      v = r_regs[addr];
`endif
    end
    return v;
  endfunction

  // Four independent combinational read ports
  always_comb begin
    rdata1_1 = f_read(raddr1_1);
    rdata1_2 = f_read(raddr1_2);
    rdata2_1 = f_read(raddr2_1);
    rdata2_2 = f_read(raddr2_2);
  end

  assign rf_write_cnt = r_write_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dual_port_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dual_port_regfile
//  Purpose  : Scoreboard bench for dual_port_regfile. Stimulus pushes expected
//             read/counter values; a negedge monitor pops and compares them.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dual_port_regfile;

  localparam int WS_TO_RF_BUS_WD = 76;
  localparam int c_sel_r11 = 0;
  localparam int c_sel_r12 = 1;
  localparam int c_sel_r21 = 2;
  localparam int c_sel_r22 = 3;
  localparam int c_sel_cnt = 4;

  logic                       clk;
  logic                       resetn;
  logic [WS_TO_RF_BUS_WD-1:0] ws_to_rf_bus;
  logic [4:0]                 raddr1_1, raddr1_2, raddr2_1, raddr2_2;
  logic [31:0]                rdata1_1, rdata1_2, rdata2_1, rdata2_2;
  logic [31:0]                rf_write_cnt;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } chk_t;

  chk_t sb[$];
  int   total = 0;
  int   bad   = 0;
  logic [31:0] exp_cnt;

  dual_port_regfile #(.WS_TO_RF_BUS_WD(WS_TO_RF_BUS_WD)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .ws_to_rf_bus (ws_to_rf_bus),
    .raddr1_1     (raddr1_1),
    .raddr1_2     (raddr1_2),
    .raddr2_1     (raddr2_1),
    .raddr2_2     (raddr2_2),
    .rdata1_1     (rdata1_1),
    .rdata1_2     (rdata1_2),
    .rdata2_1     (rdata2_1),
    .rdata2_2     (rdata2_2),
    .rf_write_cnt (rf_write_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input string n, input int s, input logic [31:0] e);
    chk_t c;
    c.name = n;
    c.sel  = s;
    c.exp  = e;
    sb.push_back(c);
  endtask

  // Expect the same value on all four read ports
  task automatic push_all(input string n, input logic [31:0] e);
    push({n, "_r11"}, c_sel_r11, e);
    push({n, "_r12"}, c_sel_r12, e);
    push({n, "_r21"}, c_sel_r21, e);
    push({n, "_r22"}, c_sel_r22, e);
  endtask

  task automatic drive(input logic we2, input logic [4:0] a2, input logic [31:0] d2,
                       input logic we1, input logic [4:0] a1, input logic [31:0] d1);
    ws_to_rf_bus = {we2, a2, d2, we1, a1, d1};
  endtask

  task automatic rd(input logic [4:0] a, input logic [4:0] b,
                    input logic [4:0] c, input logic [4:0] d);
    raddr1_1 = a;
    raddr1_2 = b;
    raddr2_1 = c;
    raddr2_2 = d;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: outputs are combinational, so every negedge is a sample point
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      chk_t        c;
      logic [31:0] act;
      c = sb.pop_front();
      case (c.sel)
        c_sel_r11: act = rdata1_1;
        c_sel_r12: act = rdata1_2;
        c_sel_r21: act = rdata2_1;
        c_sel_r22: act = rdata2_2;
        default:   act = rf_write_cnt;
      endcase
      total++;
      if (act !== c.exp) begin
        bad++;
        $display("FAIL %s: got %08h expected %08h", c.name, act, c.exp);
      end
    end
  end

  initial begin
    resetn = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    rd(5'd0, 5'd0, 5'd0, 5'd0);
    exp_cnt = 32'd0;

    // Reset state
    next_cycle();
    rd(5'd1, 5'd5, 5'd31, 5'd7);
    push_all("rst_read", 32'd0);
    push("rst_cnt", c_sel_cnt, 32'd0);
    next_cycle();
    resetn = 1'b1;

    // Dual write r5/r6
    drive(1'b1, 5'd6, 32'h2222_2222, 1'b1, 5'd5, 32'h1111_1111);
    push("pre_dual_cnt", c_sel_cnt, exp_cnt);
    next_cycle();
    exp_cnt = exp_cnt + 32'd2;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    rd(5'd5, 5'd6, 5'd6, 5'd5);
    push("dual_r5_a", c_sel_r11, 32'h1111_1111);
    push("dual_r6_a", c_sel_r12, 32'h2222_2222);
    push("dual_r6_b", c_sel_r21, 32'h2222_2222);
    push("dual_r5_b", c_sel_r22, 32'h1111_1111);
    push("dual_cnt", c_sel_cnt, exp_cnt);

    // Same-register conflict on r7: slot 2 wins, counts once
    next_cycle();
    drive(1'b1, 5'd7, 32'h5555_5555, 1'b1, 5'd7, 32'hAAAA_AAAA);
    next_cycle();
    exp_cnt = exp_cnt + 32'd1;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    rd(5'd7, 5'd7, 5'd7, 5'd7);
    push_all("conflict_r7", 32'h5555_5555);
    push("conflict_cnt", c_sel_cnt, exp_cnt);

    // r0 protection
    next_cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD_BEEF);
    rd(5'd0, 5'd0, 5'd0, 5'd0);
    push_all("r0_same", 32'd0);
    next_cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    push_all("r0_next", 32'd0);
    push("r0_cnt", c_sel_cnt, exp_cnt);

    // Bypass: r9 old value 0xAA, then write 0x1234 while reading it
    next_cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h0000_00AA);
    next_cycle();
    exp_cnt = exp_cnt + 32'd1;
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h0000_1234);
    rd(5'd5, 5'd6, 5'd7, 5'd9);
`ifdef REGFILE_BYPASS_EN
    push("byp_same_r9", c_sel_r22, 32'h0000_1234);
`else
    push("byp_same_r9", c_sel_r22, 32'h0000_00AA);
`endif
    push("byp_same_r5", c_sel_r11, 32'h1111_1111);
    next_cycle();
    exp_cnt = exp_cnt + 32'd1;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    push("byp_next_r9", c_sel_r22, 32'h0000_1234);
    push("byp_cnt", c_sel_cnt, exp_cnt);

    // Both ports hit r10 in the same cycle while reading it
    next_cycle();
    drive(1'b1, 5'd10, 32'h0BAD_F00D, 1'b1, 5'd10, 32'h0000_0010);
    rd(5'd10, 5'd10, 5'd5, 5'd6);
`ifdef REGFILE_BYPASS_EN
    push("byp_prio_r10", c_sel_r11, 32'h0BAD_F00D);
`else
    push("byp_prio_r10", c_sel_r11, 32'd0);
`endif
    next_cycle();
    exp_cnt = exp_cnt + 32'd1;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    push("prio_next_r10", c_sel_r12, 32'h0BAD_F00D);
    push("prio_cnt", c_sel_cnt, exp_cnt);

    // Asynchronous reset between edges with a write pending
    next_cycle();
    drive(1'b1, 5'd12, 32'h1212_1212, 1'b1, 5'd11, 32'hCAFE_0011);
    rd(5'd5, 5'd6, 5'd7, 5'd11);
    #2;
    resetn = 1'b0;
    exp_cnt = 32'd0;
    push_all("async_rst", 32'd0);
    push("async_rst_cnt", c_sel_cnt, 32'd0);
    next_cycle();
    rd(5'd11, 5'd12, 5'd9, 5'd10);
    push_all("in_rst", 32'd0);
    push("in_rst_cnt", c_sel_cnt, 32'd0);
    next_cycle();
    resetn = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    next_cycle();
    push_all("post_rst", 32'd0);
    push("post_rst_cnt", c_sel_cnt, 32'd0);

    // Counter wrap
    next_cycle();
    force dut.r_write_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_write_cnt;
    exp_cnt = 32'hFFFF_FFFF;
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'h0000_0C0C);
    push("wrap_pre_cnt", c_sel_cnt, exp_cnt);
    next_cycle();
    exp_cnt = exp_cnt + 32'd1;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    rd(5'd12, 5'd0, 5'd0, 5'd0);
    push("wrap_cnt", c_sel_cnt, exp_cnt);
    push("wrap_r12", c_sel_r11, 32'h0000_0C0C);

    // Drain the scoreboard
    next_cycle();
    next_cycle();
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
